// File: rtl/trap_pkg.sv
// Shared types and constants for the trap controller slice.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } trap_state_e;

  localparam int unsigned CAUSE_W = 5;

  localparam logic [CAUSE_W-1:0] CAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL          = 5'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_STORE_MISALIGNED = 5'd6;

  localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_0004;

endpackage

// File: rtl/trap_prio_arbiter.sv
// Fixed-priority selection of the winning exception: internal misalignment
// first, then external source 0 upward.
module trap_prio_arbiter
  import trap_pkg::*;
#(
  parameter int unsigned              XLEN       = 32,
  parameter int unsigned              NUM_SRC    = 3,
  parameter logic [5*NUM_SRC-1:0]     CAUSE_LIST = {5'd6, 5'd4, 5'd2}
) (
  input  logic                    mis,
  input  logic [XLEN-1:0]         pc,
  input  logic [NUM_SRC-1:0]      exc_valid,
  input  logic [NUM_SRC*XLEN-1:0] exc_pc,
  input  logic [NUM_SRC*XLEN-1:0] exc_tval,
  output logic                    hit,
  output logic [CAUSE_W-1:0]      cause,
  output logic [XLEN-1:0]         epc,
  output logic [XLEN-1:0]         tval
);

  always_comb begin
    hit   = 1'b0;
    cause = '0;
    epc   = '0;
    tval  = '0;
    if (mis) begin
      hit   = 1'b1;
      cause = CAUSE_INSTR_MISALIGNED;
      epc   = pc;
      tval  = pc;
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (!hit && exc_valid[i]) begin
          hit   = 1'b1;
          cause = CAUSE_LIST[CAUSE_W*i +: CAUSE_W];
          epc   = exc_pc[XLEN*i +: XLEN];
          tval  = exc_tval[XLEN*i +: XLEN];
        end
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap entry/return sequencer: latches mepc/mcause/mtval, flushes for one
// cycle, then redirects fetch to the handler (or to mepc on mret).
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          NUM_SRC      = 3,
  parameter int unsigned          ALIGN_BITS   = 2,
  parameter logic [XLEN-1:0]      HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
  parameter logic [5*NUM_SRC-1:0] CAUSE_LIST   = {5'd6, 5'd4, 5'd2},
  parameter int unsigned          CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pc_valid,
  input  logic [XLEN-1:0]         pc,
  input  logic [NUM_SRC-1:0]      exc_valid,
  input  logic [NUM_SRC*XLEN-1:0] exc_pc,
  input  logic [NUM_SRC*XLEN-1:0] exc_tval,
  input  logic                    mret_valid,
  input  logic                    redirect_ready,
  output logic                    flush,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    trap_active,
  output logic [XLEN-1:0]         mepc,
  output logic [XLEN-1:0]         mcause,
  output logic [XLEN-1:0]         mtval,
  output logic [CNT_W-1:0]        trap_count
);

  trap_state_e         r_state;
  trap_state_e         w_state_next;
  logic                r_ret_flag;
  logic [XLEN-1:0]     r_redirect_pc;
  logic [XLEN-1:0]     r_mepc;
  logic [CAUSE_W-1:0]  r_mcause;
  logic [XLEN-1:0]     r_mtval;
  logic [CNT_W-1:0]    r_trap_count;

  logic                w_mis;
  logic                w_hit;
  logic [CAUSE_W-1:0]  w_cause;
  logic [XLEN-1:0]     w_epc;
  logic [XLEN-1:0]     w_tval;
  logic                w_take_exc;
  logic                w_take_ret;
  logic                w_handshake;

  assign w_mis = pc_valid && (pc[ALIGN_BITS-1:0] != '0);

  trap_prio_arbiter #(
    .XLEN       (XLEN),
    .NUM_SRC    (NUM_SRC),
    .CAUSE_LIST (CAUSE_LIST)
  ) u_arb (
    .mis       (w_mis),
    .pc        (pc),
    .exc_valid (exc_valid),
    .exc_pc    (exc_pc),
    .exc_tval  (exc_tval),
    .hit       (w_hit),
    .cause     (w_cause),
    .epc       (w_epc),
    .tval      (w_tval)
  );

  // Requests only count while idle; in FLUSH/REDIRECT they are dropped.
  assign w_take_exc  = (r_state == ST_IDLE) && w_hit;
  assign w_take_ret  = (r_state == ST_IDLE) && !w_hit && mret_valid;
  assign w_handshake = (r_state == ST_REDIRECT) && redirect_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take_exc || w_take_ret) w_state_next = ST_FLUSH;
      end
      ST_FLUSH:    w_state_next = ST_REDIRECT;
      ST_REDIRECT: begin
        if (redirect_ready) w_state_next = ST_IDLE;
      end
      default:     w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_ret_flag    <= 1'b0;
      r_redirect_pc <= '0;
      r_mepc        <= '0;
      r_mcause      <= '0;
      r_mtval       <= '0;
      r_trap_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_take_exc) begin
        r_mepc     <= w_epc;
        r_mcause   <= w_cause;
        r_mtval    <= w_tval;
        r_ret_flag <= 1'b0;
      end else if (w_take_ret) begin
        r_ret_flag <= 1'b1;
      end
      // Target is frozen on entry to REDIRECT so it stays stable under stall.
      if (r_state == ST_FLUSH) begin
        r_redirect_pc <= r_ret_flag ? r_mepc : HANDLER_ADDR;
      end
      if (w_handshake && !r_ret_flag && (r_trap_count != '1)) begin
        r_trap_count <= r_trap_count + 1'b1;
      end
    end
  end

  assign flush          = (r_state == ST_FLUSH);
  assign redirect_valid = (r_state == ST_REDIRECT);
  assign trap_active    = (r_state != ST_IDLE);
  assign redirect_pc    = r_redirect_pc;
  assign mepc           = r_mepc;
  assign mcause         = {{(XLEN-CAUSE_W){1'b0}}, r_mcause};
  assign mtval          = r_mtval;
  assign trap_count     = r_trap_count;

endmodule
